// File: rtl/pdm_capture_buffer.sv
// rtl/pdm_capture_buffer.sv - capture buffer storing DEPTH packed PDM words from the sampler
module pdm_capture_buffer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       ram_data,
    input  logic              ram_wr,
    output logic              count_en,
    output logic              capturing,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LP_LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_wr_count;
    logic [31:0]       r_rd_data;
    logic [31:0]       r_mem [DEPTH];
    logic              w_wr;

    assign w_wr = rst && (r_state == S_CAPTURE) && ram_wr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state    <= S_CAPTURE;
                        r_wr_ptr   <= '0;
                        r_wr_count <= '0;
                    end
                end
                S_CAPTURE: begin
                    // A write alongside abort still commits; abort beats completion.
                    if (ram_wr) begin
                        r_wr_ptr   <= r_wr_ptr + 1'b1;
                        r_wr_count <= r_wr_count + 1'b1;
                    end
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (ram_wr && (r_wr_count == LP_LAST)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (start) begin
                        r_state    <= S_CAPTURE;
                        r_wr_ptr   <= '0;
                        r_wr_count <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage is never cleared; only the write port is gated by state.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= ram_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign count_en  = (r_state == S_CAPTURE);
    assign capturing = (r_state == S_CAPTURE);
    assign done      = (r_state == S_DONE);
    assign wr_count  = r_wr_count;
    assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_pdm_capture_buffer.sv
// tb/tb_pdm_capture_buffer.sv - self-checking bench for pdm_capture_buffer
module tb_pdm_capture_buffer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [31:0]       ram_data;
    logic              ram_wr;
    logic              count_en;
    logic              capturing;
    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;

    int total = 0;
    int bad   = 0;

    pdm_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ram_data(ram_data), .ram_wr(ram_wr),
        .count_en(count_en), .capturing(capturing), .done(done),
        .wr_count(wr_count), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: mode 0 idle, 1 capturing, 2 done; words kept in a plain array.
    int          m_mode = 0;
    int          m_cnt  = 0;
    logic [31:0] m_mem [DEPTH];
    bit          m_valid [DEPTH];
    logic [31:0] m_rd = '0;
    bit          m_rd_ok = 0;
    bit          m_live = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_mode  = 0;
            m_cnt   = 0;
            m_rd    = '0;
            m_rd_ok = 1;
            m_live  = 1;
        end else begin
            m_rd    = m_mem[rd_addr];
            m_rd_ok = m_valid[rd_addr];
            if (m_mode == 1) begin
                if (ram_wr) begin
                    m_mem[m_cnt % DEPTH]   = ram_data;
                    m_valid[m_cnt % DEPTH] = 1;
                    m_cnt = m_cnt + 1;
                end
                if (abort) m_mode = 0;
                else if (m_cnt == DEPTH) m_mode = 2;
            end else if (abort) begin
                m_mode = 0;
            end else if (start) begin
                m_mode = 1;
                m_cnt  = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_count_en", 64'(count_en), 64'(m_mode == 1));
            chk("model_capturing", 64'(capturing), 64'(m_mode == 1));
            chk("model_done", 64'(done), 64'(m_mode == 2));
            chk("model_wr_count", 64'(wr_count), 64'(m_cnt));
            if (m_rd_ok) chk("model_rd_data", 64'(rd_data), 64'(m_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic s, input logic a, input logic w, input logic [31:0] d);
        start = s; abort = a; ram_wr = w; ram_data = d;
        tick();
        start = 0; abort = 0; ram_wr = 0;
    endtask

    initial begin
        rst = 0; start = 1; abort = 0; ram_wr = 1; ram_data = 32'h5555_5555; rd_addr = '0;
        repeat (3) tick();
        chk("rst_count_en", 64'(count_en), 64'd0);
        chk("rst_capturing", 64'(capturing), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wr_count", 64'(wr_count), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        start = 0; ram_wr = 0; rst = 1;
        tick();
        chk("idle_count_en", 64'(count_en), 64'd0);

        step(1, 0, 0, '0);
        chk("start_count_en", 64'(count_en), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 32'hA000_0000 + i);
            if (i < DEPTH - 1) begin
                chk("cap_count_en_mid", 64'(count_en), 64'd1);
                tick(); tick();
            end
        end
        chk("full_done", 64'(done), 64'd1);
        chk("full_count_en", 64'(count_en), 64'd0);
        chk("full_wr_count", 64'(wr_count), 64'd8);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            tick();
            chk("full_read", 64'(rd_data), 64'(32'hA000_0000 + i));
        end

        step(0, 0, 1, 32'h1111_1111);
        step(0, 0, 1, 32'h2222_2222);
        chk("overrun_wr_count", 64'(wr_count), 64'd8);
        rd_addr = '0;
        tick();
        chk("overrun_mem0", 64'(rd_data), 64'hA000_0000);

        step(1, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hB000_0000 + i);
        step(0, 1, 1, 32'hB000_0003);
        chk("abort_wr_count", 64'(wr_count), 64'd4);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_capturing", 64'(capturing), 64'd0);

        step(0, 0, 1, 32'h1234_5678);
        chk("idle_wr_wr_count", 64'(wr_count), 64'd4);
        rd_addr = '0;
        tick();
        chk("idle_wr_mem0", 64'(rd_data), 64'hB000_0000);
        step(1, 0, 0, '0);
        chk("restart_wr_count", 64'(wr_count), 64'd0);

        step(0, 0, 1, 32'hC000_0000);
        step(0, 0, 1, 32'hC000_0001);
        step(1, 0, 0, '0);
        rd_addr = 3'd2;
        step(0, 0, 1, 32'hDEAD_BEEF);
        chk("rdw_old", 64'(rd_data), 64'hB000_0002);
        tick();
        chk("rdw_new", 64'(rd_data), 64'hDEAD_BEEF);
        chk("mid_start_wr_count", 64'(wr_count), 64'd3);

        for (int i = 3; i < DEPTH - 1; i++) step(0, 0, 1, 32'hC000_0000 + i);
        step(0, 1, 1, 32'hC000_0007);
        chk("last_abort_done", 64'(done), 64'd0);
        chk("last_abort_capturing", 64'(capturing), 64'd0);
        chk("last_abort_wr_count", 64'(wr_count), 64'd8);

        step(1, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'hE000_0000 + i);
        chk("done_again", 64'(done), 64'd1);
        step(1, 1, 0, '0);
        chk("done_sa_capturing", 64'(capturing), 64'd0);
        chk("done_sa_done", 64'(done), 64'd0);
        chk("done_sa_wr_count", 64'(wr_count), 64'd8);
        step(1, 1, 0, '0);
        chk("idle_sa_capturing", 64'(capturing), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) != 0);
            start    = ($urandom_range(0, 9) == 0);
            abort    = ($urandom_range(0, 29) == 0);
            ram_wr   = ($urandom_range(0, 1) == 1);
            ram_data = $urandom;
            rd_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            tick();
        end
        rst = 1; start = 0; abort = 0; ram_wr = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_capture_buffer.md
# pdm_capture_buffer

Capture buffer that sits directly downstream of the voice-path PDM sampler. It enables the sampler through `count_en`, stores each 32-bit packed PDM word the sampler presents on `ram_data` with `ram_wr`, and stops once `DEPTH` words are captured. A synchronous read port lets the voice processing logic fetch stored words at any time.

## Interface
- `DEPTH`, default 1024: number of 32-bit words stored; must be a power of two, ≥ 2.
- `ADDR_W`, default $clog2(DEPTH): address width.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-low (`rst==0` at a rising edge resets).
- `start` in 1: one-cycle pulse that begins a capture.
- `abort` in 1: one-cycle pulse that stops a capture early.
- `ram_data` in 32: packed PDM word from the sampler.
- `ram_wr` in 1: one-cycle write strobe from the sampler.
- `count_en` out 1: enable to the sampler; high only while capturing.
- `capturing` out 1: high in the CAPTURE state.
- `done` out 1: high in the DONE state.
- `wr_count` out ADDR_W+1: number of words written in the current or last capture.
- `rd_addr` in ADDR_W: read address.
- `rd_data` out 32: `mem[rd_addr]`, registered.

## Operation
- States: IDLE, CAPTURE, DONE. `count_en` and `capturing` are both the decoded CAPTURE state; there is no other path to them.
- **IDLE**
  - `start` → CAPTURE.
  - On entry to CAPTURE: `wr_ptr` ← 0, `wr_count` ← 0.
  - `ram_wr` is ignored.
- **CAPTURE**
  - Each `ram_wr` writes `ram_data` to `mem[wr_ptr]`, then `wr_ptr` += 1 and `wr_count` += 1.
  - The write that makes `wr_count == DEPTH` moves the state to DONE. `wr_ptr` wraps to 0 but is unused afterwards.
  - `abort` → IDLE; `wr_count` holds the words already written.
  - `start` is ignored.
- **Simultaneous events in CAPTURE**
  - `ram_wr` and `abort` together: the write completes (memory and `wr_count` update), then the state goes to IDLE.
  - If that write is the final one, the state goes to IDLE, not DONE.
- **DONE**
  - `done` = 1 and `wr_count == DEPTH`; `ram_wr` is ignored.
  - `start` → CAPTURE, with a fresh capture that clears `wr_count`.
  - `abort` → IDLE.
  - `start` and `abort` together: `abort` wins.
- **IDLE, simultaneous events:** `start` and `abort` together: `abort` wins; the state stays IDLE.
- **Memory**
  - Simple dual-port: one write port, one synchronous read port.
  - Read is unconditional in every state; `rd_data` ← `mem[rd_addr]` every cycle.
  - Read and write to the same address in the same cycle: `rd_data` returns the old contents (read-first).
  - Memory contents are not cleared by reset or by `start`.
- **Width:** `wr_count` is ADDR_W+1 bits so it can represent `DEPTH`. It never exceeds `DEPTH`.

## Timing
- **Reset** (`rst==0` at an edge): state IDLE; `count_en`=0, `capturing`=0, `done`=0, `wr_count`=0, `rd_data`=0, `wr_ptr`=0. Reset overrides all other inputs, including in the middle of a capture.
- **Start latency:** `start` sampled at edge N gives `count_en`=`capturing`=1 after edge N. The sampler's first `ram_wr` can arrive at N+1 or later.
- **Write latency:** `ram_wr` at edge K commits `mem[wr_ptr]` and increments `wr_count` at K. The new `wr_count` is visible after K.
- **Completion:** the final write at edge K gives, after K, `count_en`=0 and `done`=1 in the same cycle. `ram_wr` strobes already in flight after K are dropped.
- **Read latency:** 1 cycle. `rd_addr` sampled at edge K appears on `rd_data` after K.
- **Back-to-back:** `ram_wr` on consecutive cycles is supported at full rate. There is no backpressure; the sampler is never stalled.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `start`=1 and `ram_wr`=1 → all outputs 0 and state IDLE. Release; `start` → `count_en`=1 one cycle later.
- **Full capture** (DEPTH=8): `start`, then 8 `ram_wr` with `ram_data` = 32'hA0000000+i, spaced 3 cycles apart → `done`=1 and `count_en`=0 right after the 8th write, `wr_count`=8. Reading addresses 0..7 returns A0000000..A0000007 with 1-cycle latency.
- **Overrun:** 2 further `ram_wr` strobes in DONE → `wr_count` stays 8 and `mem[0]` is unchanged.
- **Abort:** `start`, 3 writes, then `abort` together with a 4th `ram_wr` → state IDLE, `wr_count`=4, `done`=0. A new `start` clears `wr_count` to 0.
- **Ignored inputs:** `ram_wr` in IDLE → no memory change, `wr_count` unchanged. `start` mid-capture → `wr_ptr` does not reset.
- **Read-during-write:** `rd_addr`=2 on the same edge as the write of 32'hDEADBEEF to address 2 → `rd_data` shows the old value, then 32'hDEADBEEF on the next read.
